mpshare_sched: RTL and testbench
================================

MPSHARE_SCHED -- requirements
Module: mpshare_sched

Interface
REQ-001 Parameter SLOT_MAX, default 40, meaning maximum grant window length in clk cycles per stage.
REQ-002 Parameter GAP, default 2, meaning idle cycles between windows, covering multiplier drain.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rate_i  input  4  one-hot-ish input rate; bit0 44.1k, bit1 48k, bit2 96k, bit3 192k.
REQ-006 pop_i  input  2  192k output pop; any nonzero value is a frame tick.
REQ-007 done_i  input  3  per-stage "multiply work finished"; index 0 441to48, 1 48to96, 2 96to192.
REQ-008 mpcand_i  input  72  per-stage multiplicand, stage k in bits [24k+23:24k].
REQ-009 mplier_i  input  48  per-stage multiplier, stage k in bits [16k+15:16k].
REQ-010 mpready_o  output  3  per-stage grant; at most one bit high.
REQ-011 mpcand_o  output  24  multiplicand to shared multiplier.
REQ-012 mplier_o  output  16  multiplier to shared multiplier.
REQ-013 busy_o  output  1  frame in progress (any state other than IDLE).
REQ-014 timeout_o  output  1  one-cycle pulse when a window expires without done.
REQ-015 overrun_o  output  1  one-cycle pulse when a frame tick arrives while busy.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT, GAP.
REQ-017 On a frame tick the block SHALL latch the stage-enable mask from rate_i, with the highest set rate bit winning: bit3 -> 000, bit2 -> 100, bit1 -> 110, bit0 or none -> 111.
REQ-018 rate_i SHALL be sampled only on a frame tick; changes mid-frame SHALL have no effect until the next tick.
REQ-019 Service order SHALL be stage 2, then 1, then 0, skipping disabled stages.
REQ-020 Tick in IDLE with an empty mask SHALL leave the FSM in IDLE.
REQ-021 Tick in IDLE with a non-empty mask SHALL enter GRANT for the first enabled stage the next cycle, with the window counter at 0.
REQ-022 In GRANT for stage k, mpready_o SHALL be one-hot at bit k, and the counter SHALL increment each cycle.
REQ-023 When done_i[k] is high in GRANT, the window SHALL end, and mpready_o[k] SHALL be low from the next cycle.
- done_i for non-granted stages SHALL be ignored.
REQ-024 When the counter equals SLOT_MAX-1 without done_i[k], the window SHALL end and timeout_o SHALL pulse in that same cycle.
REQ-025 After a window ends, the FSM SHALL spend exactly GAP cycles in GAP with mpready_o=000.
- It SHALL then enter GRANT for the next enabled stage, or IDLE if none remain.
REQ-026 If done_i and the timeout condition coincide, the window SHALL be treated as done; timeout_o SHALL NOT pulse.
REQ-027 A frame tick while busy SHALL pulse overrun_o, abort the current window, relatch the mask, and restart at the first enabled stage.
- The restarted window SHALL begin next cycle with the counter reset; no GAP is inserted.
REQ-028 The operand outputs SHALL be combinational: mpcand_o/mplier_o equal the granted stage's slice while in GRANT, else zero.
REQ-029 Product routing SHALL be outside this block; product-return timing SHALL be covered solely by GAP.
REQ-030 Each grant window SHALL be at most SLOT_MAX cycles long.
- A full 3-stage frame SHALL complete within 3*SLOT_MAX+2*GAP+1 cycles of the tick.

Reset
REQ-031 While rst is high, the FSM SHALL be IDLE, the counter and mask SHALL be 0, and mpready_o, busy_o, timeout_o, overrun_o, mpcand_o, mplier_o SHALL all be 0.
REQ-032 Reset SHALL take priority over a simultaneous frame tick.
REQ-033 Reset asserted mid-window SHALL drop mpready_o on the next clk edge.
REQ-034 The first tick after reset SHALL start a fresh frame with no overrun_o.

Verification
REQ-035 rate_i=0001, tick, done_i asserted 5 cycles into each window -> grants 100, 010, 001 in order, each 6 cycles long, separated by 2 idle cycles; busy_o falls after the last window.
REQ-036 rate_i=0100, tick, no done_i -> mpready_o=100 for exactly 40 cycles, timeout_o pulses once at cycle 39, then GAP, then IDLE.
REQ-037 rate_i=1000, tick -> mpready_o stays 000, busy_o stays 0.
REQ-038 rate_i=0010, second tick during the stage-1 window -> overrun_o pulses, mpready_o returns to 100 next cycle with the counter restarted.
REQ-039 done_i and counter=SLOT_MAX-1 in the same cycle -> window ends, timeout_o stays 0; done_i[0] during the stage-2 window is ignored.
REQ-040 rst pulsed mid-window with mpcand_i nonzero -> mpready_o, mpcand_o, mplier_o are 0 next cycle; next tick starts cleanly.

Source files
------------

// File: rtl/mpshare_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mpshare_sched
//  Purpose  : Time-shares one 24x16 multiplier between three sample-rate
//             conversion stages (2: 96to192, 1: 48to96, 0: 441to48). Each
//             frame tick latches the set of stages the input rate needs, then
//             grants them in order 2, 1, 0. Each grant window lasts at most
//             SLOT_MAX cycles and is followed by GAP idle cycles so the
//             multiplier pipeline can drain.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             rate_i[3:0]    - input rate select (highest set bit wins)
//             pop_i[1:0]     - frame tick when nonzero
//             done_i[2:0]    - per-stage "multiply work finished"
//             mpcand_i[71:0] - per-stage multiplicands (24 bits each)
//             mplier_i[47:0] - per-stage multipliers (16 bits each)
//             mpready_o[2:0] - one-hot grant
//             mpcand_o/mplier_o - operands of the granted stage, else 0
//             busy_o         - frame in progress
//             timeout_o      - pulse: window expired without done
//             overrun_o      - pulse: frame tick arrived while busy
//  Revision : 1.0 - initial release
// ============================================================================
module mpshare_sched #(
    parameter int SLOT_MAX = 40,
    parameter int GAP      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rate_i,
    input  logic [1:0]  pop_i,
    input  logic [2:0]  done_i,
    input  logic [71:0] mpcand_i,
    input  logic [47:0] mplier_i,
    output logic [2:0]  mpready_o,
    output logic [23:0] mpcand_o,
    output logic [15:0] mplier_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic        overrun_o
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_GRANT = 2'd1;
    localparam logic [1:0] c_S_GAP   = 2'd2;

    // One counter serves both the grant window and the gap.
    localparam int c_CNT_MAX = (SLOT_MAX > GAP) ? SLOT_MAX : GAP;
    localparam int c_CW      = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CW-1:0] c_WIN_LAST = c_CW'(SLOT_MAX - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST = c_CW'((GAP > 0) ? GAP - 1 : 0);

    logic [1:0]      r_state;
    logic [1:0]      r_stage;
    logic [2:0]      r_mask;   // stages of this frame not yet served
    logic [c_CW-1:0] r_cnt;

    logic            w_tick;
    logic [2:0]      w_rate_mask;
    logic [2:0]      w_stage_oh;
    logic            w_done;
    logic            w_win_last;
    logic            w_win_end;
    logic [2:0]      w_rem_mask;

    // Highest-priority enabled stage (2 first).
    function automatic logic [1:0] f_first(input logic [2:0] m);
        if (m[2])      return 2'd2;
        else if (m[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    assign w_tick = |pop_i;

    always_comb begin
        w_rate_mask = 3'b111;
        if (rate_i[3])      w_rate_mask = 3'b000;
        else if (rate_i[2]) w_rate_mask = 3'b100;
        else if (rate_i[1]) w_rate_mask = 3'b110;
    end

    always_comb begin
        w_stage_oh = 3'b000;
        case (r_stage)
            2'd0:    w_stage_oh = 3'b001;
            2'd1:    w_stage_oh = 3'b010;
            2'd2:    w_stage_oh = 3'b100;
            default: w_stage_oh = 3'b000;
        endcase
    end

    // Only the granted stage's done bit matters.
    assign w_done     = |(done_i & w_stage_oh);
    assign w_win_last = (r_state == c_S_GRANT) && (r_cnt == c_WIN_LAST);
    assign w_win_end  = (r_state == c_S_GRANT) && (w_done || (r_cnt == c_WIN_LAST));
    assign w_rem_mask = r_mask & ~w_stage_oh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_stage <= 2'd0;
            r_mask  <= 3'b000;
            r_cnt   <= '0;
        end else if (w_tick) begin
            // A tick always (re)starts the frame, aborting any open window.
            r_mask  <= w_rate_mask;
            r_stage <= f_first(w_rate_mask);
            r_cnt   <= '0;
            r_state <= (|w_rate_mask) ? c_S_GRANT : c_S_IDLE;
        end else begin
            case (r_state)
                c_S_GRANT: begin
                    if (w_win_end) begin
                        r_mask <= w_rem_mask;
                        r_cnt  <= '0;
                        if (GAP > 0) begin
                            r_state <= c_S_GAP;
                        end else begin
                            r_stage <= f_first(w_rem_mask);
                            r_state <= (|w_rem_mask) ? c_S_GRANT : c_S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt   <= '0;
                        r_stage <= f_first(r_mask);
                        r_state <= (|r_mask) ? c_S_GRANT : c_S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Outputs are gated by rst so they read zero for the whole reset pulse,
    // including the cycle before the registers have been cleared.
    always_comb begin
        mpready_o = 3'b000;
        mpcand_o  = 24'h0;
        mplier_o  = 16'h0;
        if (!rst && (r_state == c_S_GRANT)) begin
            mpready_o = w_stage_oh;
            case (r_stage)
                2'd0: begin
                    mpcand_o = mpcand_i[23:0];
                    mplier_o = mplier_i[15:0];
                end
                2'd1: begin
                    mpcand_o = mpcand_i[47:24];
                    mplier_o = mplier_i[31:16];
                end
                2'd2: begin
                    mpcand_o = mpcand_i[71:48];
                    mplier_o = mplier_i[47:32];
                end
                default: begin
                    mpcand_o = 24'h0;
                    mplier_o = 16'h0;
                end
            endcase
        end
    end

    assign busy_o    = !rst && (r_state != c_S_IDLE);
    // A simultaneous done wins over expiry; a tick aborts the window instead.
    assign timeout_o = !rst && !w_tick && w_win_last && !w_done;
    assign overrun_o = !rst && w_tick && (r_state != c_S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mpshare_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mpshare_sched
//  Purpose  : Self-checking bench for mpshare_sched. Each scenario builds the
//             expected per-cycle schedule of a frame from the scheduling rules
//             (stage order, window length, gap length) and replays it while
//             driving random operands, random mid-frame rate changes and
//             random done noise on non-granted stages.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mpshare_sched;

    localparam int SLOT_MAX = 40;
    localparam int GAP      = 2;
    localparam int NONE     = 1000;  // "no done in this window"

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rate_i = '0;
    logic [1:0]  pop_i = '0;
    logic [2:0]  done_i = '0;
    logic [71:0] mpcand_i = '0;
    logic [47:0] mplier_i = '0;
    logic [2:0]  mpready_o;
    logic [23:0] mpcand_o;
    logic [15:0] mplier_o;
    logic        busy_o;
    logic        timeout_o;
    logic        overrun_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] rdy;
        logic       to;
        logic       busy;
        logic       ovr;
        logic [2:0] done;
        logic       tick;
        logic [3:0] rate;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    mpshare_sched #(.SLOT_MAX(SLOT_MAX), .GAP(GAP)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rate_i    (rate_i),
        .pop_i     (pop_i),
        .done_i    (done_i),
        .mpcand_i  (mpcand_i),
        .mplier_i  (mplier_i),
        .mpready_o (mpready_o),
        .mpcand_o  (mpcand_o),
        .mplier_o  (mplier_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o),
        .overrun_o (overrun_o)
    );

    function automatic logic [2:0] rate_mask(input logic [3:0] r);
        if (r[3])      return 3'b000;
        else if (r[2]) return 3'b100;
        else if (r[1]) return 3'b110;
        else           return 3'b111;
    endfunction

    task automatic push(input logic [2:0] rdy, input logic to, input logic busy,
                        input logic ovr, input logic [2:0] done,
                        input logic tick, input logic [3:0] rate);
        ent_t e;
        e.rdy = rdy; e.to = to; e.busy = busy; e.ovr = ovr;
        e.done = done; e.tick = tick; e.rate = rate;
        q.push_back(e);
    endtask

    // Windows in order 2,1,0 for enabled stages, each followed by GAP cycles.
    task automatic add_windows(input logic [2:0] mask, input int offs[3]);
        for (int s = 2; s >= 0; s--) begin
            if (mask[s]) begin
                int len;
                logic [2:0] oh;
                oh  = 3'(1 << s);
                len = (offs[s] < SLOT_MAX) ? offs[s] + 1 : SLOT_MAX;
                for (int c = 0; c < len; c++)
                    push(oh, (offs[s] >= SLOT_MAX) && (c == SLOT_MAX - 1), 1'b1, 1'b0,
                         (c == offs[s]) ? oh : 3'b000, 1'b0, 4'h0);
                for (int g = 0; g < GAP; g++)
                    push(3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 4'h0);
            end
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++)
            push(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h0);
    endtask

    task automatic add_frame(input logic [3:0] rate, input int offs[3]);
        push(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, rate);
        add_windows(rate_mask(rate), offs);
        add_idle(2);
    endtask

    // Replays the queued schedule, one entry per clock cycle.
    task automatic run_q(input string name);
        int cyc;
        cyc = 0;
        while (q.size() > 0) begin
            ent_t e;
            logic [95:0] rc;
            logic [63:0] rp;
            logic [23:0] exp_c;
            logic [15:0] exp_p;
            int k;
            e = q.pop_front();
            @(posedge clk);
            #1;
            pop_i  = e.tick ? 2'($urandom_range(1, 3)) : 2'b00;
            rate_i = e.tick ? e.rate : 4'($urandom);
            done_i = e.done | (3'($urandom) & ~e.rdy);
            rc = {$urandom, $urandom, $urandom};
            rp = {$urandom, $urandom};
            mpcand_i = rc[71:0];
            mplier_i = rp[47:0];
            @(negedge clk);
            k = e.rdy[2] ? 2 : (e.rdy[1] ? 1 : 0);
            exp_c = (e.rdy != 3'b000) ? mpcand_i[24*k +: 24] : 24'h0;
            exp_p = (e.rdy != 3'b000) ? mplier_i[16*k +: 16] : 16'h0;
            n_tests++;
            if (mpready_o !== e.rdy) begin
                n_fail++;
                $display("FAIL %s cyc%0d mpready_o got %b exp %b", name, cyc, mpready_o, e.rdy);
            end
            n_tests++;
            if (busy_o !== e.busy) begin
                n_fail++;
                $display("FAIL %s cyc%0d busy_o got %b exp %b", name, cyc, busy_o, e.busy);
            end
            n_tests++;
            if (timeout_o !== e.to) begin
                n_fail++;
                $display("FAIL %s cyc%0d timeout_o got %b exp %b", name, cyc, timeout_o, e.to);
            end
            n_tests++;
            if (overrun_o !== e.ovr) begin
                n_fail++;
                $display("FAIL %s cyc%0d overrun_o got %b exp %b", name, cyc, overrun_o, e.ovr);
            end
            n_tests++;
            if ((mpcand_o !== exp_c) || (mplier_o !== exp_p)) begin
                n_fail++;
                $display("FAIL %s cyc%0d operands got %h/%h exp %h/%h",
                         name, cyc, mpcand_o, mplier_o, exp_c, exp_p);
            end
            cyc++;
        end
        #1;
        pop_i  = 2'b00;
        done_i = 3'b000;
    endtask

    task automatic check_quiet(input string name);
        n_tests++;
        if ({mpready_o, busy_o, timeout_o, overrun_o, mpcand_o, mplier_o} !== '0) begin
            n_fail++;
            $display("FAIL %s outputs got rdy=%b busy=%b to=%b ovr=%b cand=%h plier=%h exp all 0",
                     name, mpready_o, busy_o, timeout_o, overrun_o, mpcand_o, mplier_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mpcand_i = 72'hFFFFFFFFFFFFFFFFFF;
        mplier_i = 48'hFFFFFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            pop_i  = 2'b11;     // tick during reset must be ignored
            rate_i = 4'b0001;
            done_i = 3'b111;
            @(negedge clk);
            check_quiet("reset_hold");
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        pop_i  = 2'b00;
        done_i = 3'b000;
        @(negedge clk);
        check_quiet("reset_release");
    endtask

    task automatic test_all_stages_done();
        add_frame(4'b0001, '{5, 5, 5});
        run_q("all_stages_done");
    endtask

    task automatic test_timeout();
        add_frame(4'b0100, '{NONE, NONE, NONE});
        run_q("timeout");
    endtask

    task automatic test_rate192();
        add_frame(4'b1000, '{0, 0, 0});
        run_q("rate192");
    endtask

    task automatic test_done_at_limit();
        add_frame(4'b0001, '{SLOT_MAX - 1, SLOT_MAX - 1, SLOT_MAX - 1});
        run_q("done_at_limit");
    endtask

    task automatic test_overrun();
        push(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'b0010);
        for (int c = 0; c < 3; c++)
            push(3'b100, 1'b0, 1'b1, 1'b0, (c == 2) ? 3'b100 : 3'b000, 1'b0, 4'h0);
        for (int g = 0; g < GAP; g++)
            push(3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 4'h0);
        for (int c = 0; c < 3; c++)
            push(3'b010, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 4'h0);
        // second tick inside the stage-1 window
        push(3'b010, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 4'b0010);
        // full-length restart proves the counter went back to 0
        add_windows(3'b110, '{NONE, NONE, NONE});
        add_idle(2);
        run_q("overrun");
    endtask

    task automatic test_reset_mid();
        push(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'b0100);
        for (int c = 0; c < 10; c++)
            push(3'b100, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 4'h0);
        run_q("reset_mid_pre");
        @(posedge clk);
        #1;
        rst      = 1'b1;
        pop_i    = 2'b01;
        mpcand_i = 72'hA5A5A5A5A5A5A5A5A5;
        mplier_i = 48'h5A5A5A5A5A5A;
        @(negedge clk);
        check_quiet("reset_mid_hold");
        @(posedge clk);
        #1;
        rst   = 1'b0;
        pop_i = 2'b00;
        @(negedge clk);
        check_quiet("reset_mid_after");
        add_frame(4'b0010, '{3, 7, 11});
        run_q("reset_mid_fresh");
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            int offs[3];
            logic [3:0] r;
            r = 4'($urandom);
            for (int s = 0; s < 3; s++) begin
                if ($urandom_range(0, 3) == 0)      offs[s] = NONE;
                else if ($urandom_range(0, 3) == 0) offs[s] = SLOT_MAX - 1;
                else                                offs[s] = $urandom_range(0, SLOT_MAX - 1);
            end
            add_frame(r, offs);
            add_idle($urandom_range(0, 2));
            run_q("random");
        end
    endtask

    initial begin
        test_reset();
        test_all_stages_done();
        test_timeout();
        test_rate192();
        test_done_at_limit();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
